// File: rtl/bcd_conv_scheduler.sv
// rtl/bcd_conv_scheduler.sv - shares one binary-to-BCD converter across six DCF77 time fields
// Snapshot, six timed conversions, then one atomic commit to the display registers.
module bcd_conv_scheduler #(
  parameter int CONV_WAIT = 12
) (
  input  logic       clk_in,
  input  logic       GSR,
  input  logic       start,
  input  logic [6:0] f_sec,
  input  logic [6:0] f_min,
  input  logic [6:0] f_hour,
  input  logic [6:0] f_day,
  input  logic [6:0] f_month,
  input  logic [6:0] f_year,
  output logic       conv_sync,
  output logic [6:0] conv_num,
  input  logic [7:0] conv_cifre,
  output logic [7:0] bcd_sec,
  output logic [7:0] bcd_min,
  output logic [7:0] bcd_hour,
  output logic [7:0] bcd_day,
  output logic [7:0] bcd_month,
  output logic [7:0] bcd_year,
  output logic       busy,
  output logic       done,
  output logic [5:0] range_err
);

  localparam int CNT_W = $clog2(CONV_WAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CAPTURE, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [5:0][6:0] snap_q, snap_d;
  logic [5:0]      err_q, err_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [5:0][7:0] bcd_q, bcd_d;
  logic [5:0]      range_err_q, range_err_d;
  logic [5:0][6:0] fields;
  logic            take_snap;

  assign fields = {f_year, f_month, f_day, f_hour, f_min, f_sec};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    snap_d      = snap_q;
    err_d       = err_q;
    shadow_d    = shadow_q;
    bcd_d       = bcd_q;
    range_err_d = range_err_q;
    take_snap   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          take_snap = 1'b1;
          idx_d     = 3'd0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        pending_d = pending_q | start;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        pending_d = pending_q | start;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CONV_WAIT - 1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        pending_d         = pending_q | start;
        shadow_d[idx_q]   = conv_cifre;
        if (idx_q == 3'd5) begin
          // bcd_* are loaded here so they are visible during the COMMIT cycle together with done
          bcd_d       = shadow_d;
          range_err_d = err_q;
          state_d     = S_COMMIT;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD;
        end
      end
      S_COMMIT: begin
        // A start seen in COMMIT folds into the rerun rather than queuing a third run
        pending_d = 1'b0;
        if (pending_q || start) begin
          take_snap = 1'b1;
          idx_d     = 3'd0;
          state_d   = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_snap) begin
      for (int i = 0; i < 6; i++) begin
        if (fields[i] > 7'd99) begin
          snap_d[i] = 7'd99;
          err_d[i]  = 1'b1;
        end else begin
          snap_d[i] = fields[i];
          err_d[i]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge GSR) begin
    if (GSR) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      snap_q      <= '0;
      err_q       <= '0;
      shadow_q    <= '0;
      bcd_q       <= '0;
      range_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      snap_q      <= snap_d;
      err_q       <= err_d;
      shadow_q    <= shadow_d;
      bcd_q       <= bcd_d;
      range_err_q <= range_err_d;
    end
  end

  assign conv_sync = (state_q == S_LOAD);
  assign conv_num  = snap_q[idx_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_COMMIT);
  assign range_err = range_err_q;
  assign bcd_sec   = bcd_q[0];
  assign bcd_min   = bcd_q[1];
  assign bcd_hour  = bcd_q[2];
  assign bcd_day   = bcd_q[3];
  assign bcd_month = bcd_q[4];
  assign bcd_year  = bcd_q[5];

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb/tb_bcd_conv_scheduler.sv - self-checking bench for bcd_conv_scheduler
// Includes a behavioural converter that only presents its result 10 edges after sync.
module tb_bcd_conv_scheduler;

  localparam int CW  = 12;
  localparam int LAT = 6 * (CW + 2) + 1;

  logic       clk_in = 1'b0;
  logic       GSR = 1'b1;
  logic       start = 1'b0;
  logic [6:0] f_sec = '0, f_min = '0, f_hour = '0, f_day = '0, f_month = '0, f_year = '0;
  logic       conv_sync;
  logic [6:0] conv_num;
  logic [7:0] conv_cifre = 8'h00;
  logic [7:0] bcd_sec, bcd_min, bcd_hour, bcd_day, bcd_month, bcd_year;
  logic       busy, done;
  logic [5:0] range_err;
  logic [47:0] bcd_all;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fv[6];
  int sync_q[$];
  int done_q[$];
  int cv_num = 0;
  int cv_age = 100;

  bcd_conv_scheduler #(.CONV_WAIT(CW)) dut (
    .clk_in(clk_in), .GSR(GSR), .start(start),
    .f_sec(f_sec), .f_min(f_min), .f_hour(f_hour), .f_day(f_day), .f_month(f_month), .f_year(f_year),
    .conv_sync(conv_sync), .conv_num(conv_num), .conv_cifre(conv_cifre),
    .bcd_sec(bcd_sec), .bcd_min(bcd_min), .bcd_hour(bcd_hour), .bcd_day(bcd_day),
    .bcd_month(bcd_month), .bcd_year(bcd_year),
    .busy(busy), .done(done), .range_err(range_err)
  );

  assign bcd_all = {bcd_year, bcd_month, bcd_day, bcd_hour, bcd_min, bcd_sec};

  always #5 clk_in = ~clk_in;

  function automatic int clamp99(int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic logic [7:0] m_bcd(int v);
    int c;
    c = clamp99(v);
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [47:0] exp_word();
    logic [47:0] w;
    for (int i = 0; i < 6; i++) w[i*8 +: 8] = m_bcd(fv[i]);
    return w;
  endfunction

  function automatic logic [5:0] exp_err();
    logic [5:0] e;
    for (int i = 0; i < 6; i++) e[i] = (fv[i] > 99);
    return e;
  endfunction

  // Converter: wrong value until 10 edges after sync, correct value afterwards
  always @(posedge clk_in) begin
    cyc++;
    if (conv_sync) begin
      cv_num = int'(conv_num);
      cv_age = 0;
      conv_cifre <= ~m_bcd(cv_num);
    end else begin
      if (cv_age < 100) cv_age++;
      if (cv_age == 10) conv_cifre <= m_bcd(cv_num);
    end
  end

  always @(negedge clk_in) begin
    if (conv_sync) sync_q.push_back(int'(conv_num));
    if (done) done_q.push_back(cyc);
  end

  task automatic set_fields();
    f_sec = 7'(fv[0]); f_min = 7'(fv[1]); f_hour = 7'(fv[2]);
    f_day = 7'(fv[3]); f_month = 7'(fv[4]); f_year = 7'(fv[5]);
  endtask

  task automatic pulse_start(output int e0);
    @(negedge clk_in);
    start = 1'b1;
    @(posedge clk_in);
    #1;
    start = 1'b0;
    e0 = cyc - 1;
  endtask

  task automatic wait_to(input int t);
    do @(negedge clk_in); while (cyc < t);
  endtask

  task automatic start_at(input int t);
    wait_to(t);
    start = 1'b1;
    @(posedge clk_in);
    #1;
    start = 1'b0;
  endtask

  task automatic run_one(input string name);
    int e0;
    set_fields();
    sync_q.delete();
    done_q.delete();
    pulse_start(e0);
    wait_to(e0 + LAT + 5);
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== e0 + LAT) begin
      failures++;
      $display("FAIL %s done_cycle got_count=%0d got_cycle=%0d exp_cycle=%0d", name, done_q.size(),
               (done_q.size() > 0) ? done_q[0] - e0 : -1, LAT);
    end
    checks++;
    if (sync_q.size() !== 6) begin
      failures++;
      $display("FAIL %s sync_count got=%0d exp=6", name, sync_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (sync_q[i] !== clamp99(fv[i])) begin
          failures++;
          $display("FAIL %s conv_num[%0d] got=%0d exp=%0d", name, i, sync_q[i], clamp99(fv[i]));
        end
      end
    end
    checks++;
    if (bcd_all !== exp_word()) begin
      failures++;
      $display("FAIL %s bcd got=%h exp=%h", name, bcd_all, exp_word());
    end
    checks++;
    if (range_err !== exp_err()) begin
      failures++;
      $display("FAIL %s range_err got=%b exp=%b", name, range_err, exp_err());
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after got=%b exp=0", name, busy);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bcd_all, range_err, conv_sync, conv_num, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset outputs got=%h exp=0", {bcd_all, range_err, conv_sync, conv_num, busy, done});
    end
    @(negedge clk_in);
    GSR = 1'b0;
    sync_q.delete();
    done_q.delete();
    repeat (20) @(negedge clk_in);
    checks++;
    if (sync_q.size() !== 0 || done_q.size() !== 0) begin
      failures++;
      $display("FAIL reset_idle syncs=%0d dones=%0d exp=0", sync_q.size(), done_q.size());
    end
  endtask

  task automatic test_nominal();
    fv = '{59, 7, 23, 31, 12, 99};
    run_one("nominal");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) fv[i] = int'($urandom_range(0, 127));
      run_one("random");
    end
  endtask

  task automatic test_out_of_range();
    fv = '{0, 100, 127, 0, 0, 0};
    run_one("out_of_range");
  endtask

  task automatic test_snapshot_isolation();
    int e0;
    fv = '{1, 2, 5, 4, 3, 6};
    set_fields();
    pulse_start(e0);
    wait_to(e0 + 2);
    f_hour = 7'd17;
    f_sec = 7'd88;
    wait_to(e0 + LAT + 2);
    checks++;
    if (bcd_all !== exp_word()) begin
      failures++;
      $display("FAIL snapshot bcd got=%h exp=%h", bcd_all, exp_word());
    end
  endtask

  task automatic test_pending();
    int e0;
    logic [47:0] w;
    for (int i = 0; i < 6; i++) fv[i] = int'($urandom_range(0, 99));
    fv[0] = 10;
    set_fields();
    sync_q.delete();
    done_q.delete();
    pulse_start(e0);
    start_at(e0 + 20);
    start_at(e0 + 40);
    wait_to(e0 + 84);
    f_sec = 7'd42;
    start_at(e0 + 85);
    wait_to(e0 + 3 * LAT);
    fv[0] = 42;
    w = exp_word();
    checks++;
    if (done_q.size() !== 2) begin
      failures++;
      $display("FAIL pending done_count got=%0d exp=2", done_q.size());
    end else begin
      checks++;
      if (done_q[0] !== e0 + LAT || done_q[1] !== e0 + 2 * LAT) begin
        failures++;
        $display("FAIL pending done_cycles got=%0d,%0d exp=%0d,%0d", done_q[0] - e0, done_q[1] - e0, LAT, 2 * LAT);
      end
    end
    checks++;
    if (sync_q.size() !== 12) begin
      failures++;
      $display("FAIL pending sync_count got=%0d exp=12", sync_q.size());
    end else begin
      checks++;
      if (sync_q[0] !== 10 || sync_q[6] !== 42) begin
        failures++;
        $display("FAIL pending sec_conv got=%0d,%0d exp=10,42", sync_q[0], sync_q[6]);
      end
    end
    checks++;
    if (bcd_all !== w) begin
      failures++;
      $display("FAIL pending bcd got=%h exp=%h", bcd_all, w);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    fv = '{45, 30, 12, 1, 6, 24};
    set_fields();
    done_q.delete();
    pulse_start(e0);
    wait_to(e0 + LAT + 1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b busy_after_commit got=%b exp=0", busy);
    end
    start = 1'b1;
    fv = '{3, 4, 5, 6, 7, 8};
    set_fields();
    @(posedge clk_in);
    #1;
    start = 1'b0;
    wait_to(e0 + 2 * LAT + 5);
    checks++;
    if (done_q.size() !== 2 || done_q[1] !== e0 + LAT + 1 + LAT) begin
      failures++;
      $display("FAIL b2b second_done got_count=%0d exp_cycle=%0d", done_q.size(), 2 * LAT + 1);
    end
    checks++;
    if (bcd_all !== exp_word()) begin
      failures++;
      $display("FAIL b2b bcd got=%h exp=%h", bcd_all, exp_word());
    end
  endtask

  task automatic test_reset_mid_run();
    int e0;
    fv = '{11, 22, 33, 44, 55, 66};
    set_fields();
    pulse_start(e0);
    start_at(e0 + 20);
    wait_to(e0 + 40);
    #2;
    GSR = 1'b1;
    #1;
    checks++;
    if ({bcd_all, range_err, conv_sync, conv_num, busy, done} !== '0) begin
      failures++;
      $display("FAIL midrun_async outputs got=%h exp=0", {bcd_all, range_err, conv_sync, conv_num, busy, done});
    end
    @(negedge clk_in);
    GSR = 1'b0;
    sync_q.delete();
    done_q.delete();
    repeat (2 * LAT) @(negedge clk_in);
    checks++;
    if (sync_q.size() !== 0 || done_q.size() !== 0 || bcd_all !== '0) begin
      failures++;
      $display("FAIL midrun_quiet syncs=%0d dones=%0d bcd=%h exp=0", sync_q.size(), done_q.size(), bcd_all);
    end
    for (int i = 0; i < 6; i++) fv[i] = int'($urandom_range(0, 127));
    run_one("after_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_out_of_range();
    test_snapshot_isolation();
    test_pending();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
